seg_scroll_display: RTL and testbench



---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg7_decode.sv | 11 +
 rtl/seg_scroll_display.sv | 139 +++++++++++++
 tb/tb_seg_scroll_display.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the scrolling seven-segment display: character codes,
// mode encodings and the active-low {g,f,e,d,c,b,a} glyph table.
package seg_pkg;

  localparam logic [4:0] CODE_BLANK = 5'h10;
  localparam logic [4:0] CODE_DASH  = 5'h11;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_LEFT   = 2'b01;
  localparam logic [1:0] MODE_RIGHT  = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Codes 0x12..0x1F are unassigned and render as blank.
  function automatic logic [6:0] seg_glyph(input logic [4:0] code);
    if (!code[4])
      return GLYPH_TABLE[code[3:0]];
    else if (code == CODE_DASH)
      return SEG_DASH;
    else
      return SEG_OFF;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational character-code to active-low seven-segment decoder.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [6:0] o_seg
);

  assign o_seg = seg_glyph(i_code);

endmodule

// File: rtl/seg_scroll_display.sv
// Multi-digit seven-segment message display with static/scroll/freeze window.
// Optional blink feature enabled by defining SEG_BLINK_EN.
module seg_scroll_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int DEPTH      = 8,
  parameter int TICK_DIV   = 50_000_000
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_DIV  = 25_000_000
`endif
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [4:0]                 wr_data,
  input  logic [1:0]                 mode,
  input  logic [$clog2(DEPTH)-1:0]   start_sel,
`ifdef SEG_BLINK_EN
  input  logic                       blink,
`endif
  output logic [7*NUM_DIGITS-1:0]    seg_out,
  output logic [$clog2(DEPTH)-1:0]   pos,
  output logic                       wrap
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [4:0]              r_buf [DEPTH];
  logic [CW-1:0]           r_cnt;
  logic [AW-1:0]           r_pos;
  logic                    r_wrap;
  logic [7*NUM_DIGITS-1:0] r_seg;
  logic                    w_scroll;
  logic                    w_tick;
  logic [6:0]              w_glyph [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] w_seg_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= CODE_BLANK;
    end else if (wr_en) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  assign w_scroll = (mode == MODE_LEFT) || (mode == MODE_RIGHT);
  assign w_tick   = w_scroll && (r_cnt == CW'(TICK_DIV - 1));

  // Counter is held at zero outside scroll modes so a fresh scroll waits a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (!w_scroll || w_tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      case (mode)
        MODE_STATIC: r_pos <= start_sel;
        MODE_LEFT: if (w_tick) begin
          r_pos  <= r_pos + 1'b1;
          r_wrap <= (r_pos == AW'(DEPTH - 1));
        end
        MODE_RIGHT: if (w_tick) begin
          r_pos  <= r_pos - 1'b1;
          r_wrap <= (r_pos == '0);
        end
        default: r_pos <= r_pos;
      endcase
    end
  end

  // Window index wraps for free because DEPTH is a power of two.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [AW-1:0] w_idx;
    assign w_idx = r_pos + AW'(g);
    seg7_decode u_decode (
      .i_code (r_buf[w_idx]),
      .o_seg  (w_glyph[g])
    );
  end

  always_comb begin
    w_seg_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      w_seg_next[7*(NUM_DIGITS-i)-1 -: 7] = w_glyph[i];
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_seg <= '1;
    else if (blink && r_phase)
      r_seg <= '1;
    else
      r_seg <= w_seg_next;
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_seg <= '1;
    else
      r_seg <= w_seg_next;
  end
`endif

  assign seg_out = r_seg;
  assign pos     = r_pos;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_seg_scroll_display.sv
// Self-checking bench for seg_scroll_display: directed scenarios followed by
// randomized writes/mode changes, all compared against a behavioural model.
module tb_seg_scroll_display;

  localparam int ND    = 3;
  localparam int DEPTH = 8;
  localparam int TD    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [4:0]  wr_data = '0;
  logic [1:0]  mode = 2'b00;
  logic [2:0]  start_sel = '0;
  logic [20:0] seg_out;
  logic [2:0]  pos;
  logic        wrap;
`ifdef SEG_BLINK_EN
  logic        blink = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  int          mBuf [DEPTH];
  int          mPos;
  int          mCnt;
  bit          mWrap;
  logic [20:0] mSeg;

  logic [6:0] hexGlyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg_scroll_display #(
    .NUM_DIGITS (ND),
    .DEPTH      (DEPTH),
    .TICK_DIV   (TD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mode      (mode),
    .start_sel (start_sel),
`ifdef SEG_BLINK_EN
    .blink     (blink),
`endif
    .seg_out   (seg_out),
    .pos       (pos),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyphOf(input int code);
    if (code < 16) return hexGlyph[code];
    if (code == 17) return 7'b0111111;
    return 7'b1111111;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) mBuf[i] = 16;
    mPos  = 0;
    mCnt  = 0;
    mWrap = 0;
    mSeg  = '1;
  endtask

  // One clock edge of the reference: display is built from the pre-edge buffer and window.
  task automatic modelEdge();
    logic [20:0] nextSeg;
    bit tick;
    if (!rst_n) begin
      modelReset();
      return;
    end
    for (int i = 0; i < ND; i++)
      nextSeg[20 - 7*i -: 7] = glyphOf(mBuf[(mPos + i) % DEPTH]);
    tick = 0;
    if (mode == 2'b01 || mode == 2'b10) begin
      tick = (mCnt == TD - 1);
      mCnt = tick ? 0 : mCnt + 1;
    end else begin
      mCnt = 0;
    end
    mWrap = 0;
    case (mode)
      2'b00: mPos = start_sel;
      2'b01: if (tick) begin
        mWrap = (mPos == DEPTH - 1);
        mPos  = (mPos + 1) % DEPTH;
      end
      2'b10: if (tick) begin
        mWrap = (mPos == 0);
        mPos  = (mPos + DEPTH - 1) % DEPTH;
      end
      default: ;
    endcase
    if (wr_en) mBuf[wr_addr] = wr_data;
    mSeg = nextSeg;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("seg", seg_out, mSeg);
      checkOutput("pos", pos, mPos);
      checkOutput("wrap", wrap, mWrap);
    end
  endtask

  task automatic pulseReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_seg", seg_out, 21'h1FFFFF);
    checkOutput("async_rst_pos", pos, 0);
    checkOutput("async_rst_wrap", wrap, 0);
    modelReset();
    #4;
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_addr   = 3'($urandom_range(0, DEPTH - 1));
      wr_data   = 5'($urandom_range(0, 31));
      start_sel = 3'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) pulseReset();
      runCycles(1);
    end
  endtask

  initial begin
    modelReset();
    #12;
    checkOutput("rst_seg", seg_out, 21'h1FFFFF);
    checkOutput("rst_pos", pos, 0);
    checkOutput("rst_wrap", wrap, 0);
    rst_n = 1'b1;

    // Load 0..7, the first write landing on the very first edge after reset.
    for (int a = 0; a < DEPTH; a++) begin
      wr_en   = 1'b1;
      wr_addr = 3'(a);
      wr_data = 5'(a);
      runCycles(1);
    end
    wr_en     = 1'b0;
    start_sel = 3'd6;
    runCycles(2);
    checkOutput("static_pos", pos, 6);
    checkOutput("static_seg", seg_out, {7'b0000010, 7'b1111000, 7'b1000000});

    start_sel = 3'd0;
    runCycles(2);
    mode = 2'b01;
    for (int k = 1; k <= DEPTH; k++) begin
      runCycles(TD);
      checkOutput("left_pos", pos, k % DEPTH);
      checkOutput("left_wrap", wrap, (k == DEPTH) ? 1 : 0);
    end
    runCycles(1);
    checkOutput("left_wrap_drop", wrap, 0);

    mode = 2'b00;
    runCycles(2);
    mode = 2'b10;
    runCycles(TD);
    checkOutput("right_pos7", pos, 7);
    checkOutput("right_wrap", wrap, 1);
    runCycles(TD);
    checkOutput("right_pos6", pos, 6);
    mode = 2'b11;
    runCycles(20);
    checkOutput("freeze_pos", pos, 6);

    // Write a dash into the entry that becomes window start on the same tick.
    mode = 2'b01;
    for (int k = 0; k < 2 * TD && mCnt != TD - 1; k++) runCycles(1);
    wr_en   = 1'b1;
    wr_addr = 3'((mPos + 1) % DEPTH);
    wr_data = 5'h11;
    runCycles(1);
    wr_en = 1'b0;
    runCycles(1);
    checkOutput("tick_write_dash", seg_out[20:14], 7'b0111111);

    runCycles(2);
    pulseReset();
    runCycles(3);

    applyStimulus(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
